// File: rtl/dmem_pkg.sv
// Shared types and default widths for the data-memory responder.
package dmem_pkg;

    localparam int DATA_W_DEF     = 16;
    localparam int ADDR_W_DEF     = 8;
    localparam int RD_LATENCY_DEF = 2;
    localparam int Q_DEPTH_DEF    = 4;
    localparam int REQ_ADDR_W     = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef enum logic {
        LOAD  = 1'b0,
        STORE = 1'b1
    } kind_e;

    // Default-width queue entry; the responder builds its own when widths are overridden.
    typedef struct packed {
        kind_e                  kind;
        logic [ADDR_W_DEF-1:0]  addr;
        logic [DATA_W_DEF-1:0]  wdata;
    } qentry_t;

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response channel between the MEM stage and the data-memory responder.
// resp_err exists only when DMEM_RANGE_CHECK_EN is defined.
interface dmem_responder_if
    import dmem_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int Q_DEPTH = Q_DEPTH_DEF
);
    logic                     req_valid;
    logic                     req_ready;
    logic                     req_rd;
    logic                     req_wr;
    logic [REQ_ADDR_W-1:0]    req_addr;
    logic [DATA_W-1:0]        req_wdata;
    logic                     resp_valid;
    logic                     resp_ready;
    logic [DATA_W-1:0]        resp_rdata;
    logic [$clog2(Q_DEPTH):0] pending;
`ifdef DMEM_RANGE_CHECK_EN
    logic                     resp_err;
`endif

    modport master (
        output req_valid, req_rd, req_wr, req_addr, req_wdata, resp_ready,
`ifdef DMEM_RANGE_CHECK_EN
        input  resp_err,
`endif
        input  req_ready, resp_valid, resp_rdata, pending
    );

    modport slave (
        input  req_valid, req_rd, req_wr, req_addr, req_wdata, resp_ready,
`ifdef DMEM_RANGE_CHECK_EN
        output resp_err,
`endif
        output req_ready, resp_valid, resp_rdata, pending
    );

endinterface

// File: rtl/dmem_req_fifo.sv
// In-order request queue with full/empty/occupancy flags.
// Latency: a pushed entry is visible at pop_dat the cycle after the push edge.
// Backpressure: push ignored when full, pop ignored when empty; no pass-through.
module dmem_req_fifo
    import dmem_pkg::*;
#(
    parameter int  DEPTH   = Q_DEPTH_DEF,
    parameter type entry_t = qentry_t
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   push,
    input  entry_t                 push_dat,
    input  logic                   pop,
    output entry_t                 pop_dat,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int               PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= PTR_W'(wr_ptr + 1'b1);
            if (do_pop)  rd_ptr <= PTR_W'(rd_ptr + 1'b1);
            case ({do_push, do_pop})
                2'b10:   count <= (PTR_W+1)'(count + 1'b1);
                2'b01:   count <= (PTR_W+1)'(count - 1'b1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

    assign pop_dat = mem[rd_ptr];
    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: queued loads/stores, stores 1/cycle, loads one at a time; DMEM_RANGE_CHECK_EN adds resp_err.
// Latency: load accepted at edge t into an idle empty queue -> resp_valid after edge t+1+RD_LATENCY.
// Backpressure: req_ready = !full (and low in reset); a held response blocks all later requests.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int RD_LATENCY = RD_LATENCY_DEF,
    parameter int Q_DEPTH    = Q_DEPTH_DEF
) (
    input  logic             CLK,
    input  logic             RST,
    dmem_responder_if.slave  bus
);
    localparam int               CNT_W    = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(RD_LATENCY - 1);
    localparam logic [1:0]       IDLE     = ST_IDLE;
    localparam logic [1:0]       WAIT     = ST_WAIT;
    localparam logic [1:0]       RESP     = ST_RESP;

    typedef struct packed {
        kind_e              kind;
`ifdef DMEM_RANGE_CHECK_EN
        logic               oor;
`endif
        logic [ADDR_W-1:0]  addr;
        logic [DATA_W-1:0]  wdata;
    } entry_t;

    logic [DATA_W-1:0] mem [2**ADDR_W];

    entry_t            in_e;
    entry_t            head;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic              wr_en;
    logic [1:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] cap_q;
    logic [DATA_W-1:0] rdata_q;

    assign bus.req_ready = !full && !RST;
    // Bubbles (neither rd nor wr) are accepted but never enqueued.
    assign push = bus.req_valid && bus.req_ready && (bus.req_rd || bus.req_wr);

    always_comb begin
        in_e       = '0;
        in_e.kind  = bus.req_wr ? STORE : LOAD;
        in_e.addr  = bus.req_addr[ADDR_W-1:0];
        in_e.wdata = bus.req_wdata;
`ifdef DMEM_RANGE_CHECK_EN
        in_e.oor   = |bus.req_addr[REQ_ADDR_W-1:ADDR_W];
`endif
    end

`ifndef DMEM_RANGE_CHECK_EN
    logic unused_addr_hi;
    assign unused_addr_hi = |bus.req_addr[REQ_ADDR_W-1:ADDR_W];
`endif

    dmem_req_fifo #(
        .DEPTH   (Q_DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .CLK      (CLK),
        .RST      (RST),
        .push     (push),
        .push_dat (in_e),
        .pop      (pop),
        .pop_dat  (head),
        .full     (full),
        .empty    (empty),
        .count    (bus.pending)
    );

    assign pop = !RST && (state == IDLE) && !empty;
`ifdef DMEM_RANGE_CHECK_EN
    assign wr_en = pop && (head.kind == STORE) && !head.oor;
    logic cap_err_q;
    logic err_q;
    assign bus.resp_err = err_q;
`else
    assign wr_en = pop && (head.kind == STORE);
`endif

    always_ff @(posedge CLK) begin
        if (wr_en) mem[head.addr] <= head.wdata;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            cnt       <= '0;
            cap_q     <= '0;
            rdata_q   <= '0;
`ifdef DMEM_RANGE_CHECK_EN
            cap_err_q <= 1'b0;
            err_q     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (!empty && head.kind == LOAD) begin
                        state     <= WAIT;
                        cnt       <= CNT_INIT;
`ifdef DMEM_RANGE_CHECK_EN
                        cap_q     <= head.oor ? '0 : mem[head.addr];
                        cap_err_q <= head.oor;
`else
                        cap_q     <= mem[head.addr];
`endif
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        state   <= RESP;
                        rdata_q <= cap_q;
`ifdef DMEM_RANGE_CHECK_EN
                        err_q   <= cap_err_q;
`endif
                    end else begin
                        cnt <= CNT_W'(cnt - 1'b1);
                    end
                end
                RESP: begin
                    if (bus.resp_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.resp_valid = (state == RESP);
    assign bus.resp_rdata = rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: stimulus pushes expected load data, a negedge monitor checks responses.
module tb_dmem_responder;

    logic CLK;
    logic RST;

    dmem_responder_if #(.DATA_W(16), .Q_DEPTH(4)) bus ();

    dmem_responder #(
        .DATA_W     (16),
        .ADDR_W     (8),
        .RD_LATENCY (2),
        .Q_DEPTH    (4)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    typedef struct {
        logic [15:0] d;
        logic        e;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   errors   = 0;
    int   resp_cnt = 0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Present one request and return just after the edge that accepted it.
    task automatic send(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] d);
        int n = 0;
        bus.req_valid = 1'b1;
        bus.req_rd    = rd;
        bus.req_wr    = wr;
        bus.req_addr  = a;
        bus.req_wdata = d;
        while (!bus.req_ready && n < 200) begin
            tick();
            n++;
        end
        chk("req_accept_timeout", 32'(n >= 200), 32'd0);
        tick();
        bus.req_valid = 1'b0;
        bus.req_rd    = 1'b0;
        bus.req_wr    = 1'b0;
    endtask

    task automatic expect_load(input logic [15:0] a, input logic [15:0] d, input logic e);
        sb.push_back('{d, e});
        send(1'b1, 1'b0, a, 16'h0);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((sb.size() != 0 || bus.pending != 0 || bus.resp_valid) && n < 500) begin
            tick();
            n++;
        end
        chk("drain_timeout", 32'(n >= 500), 32'd0);
        repeat (3) tick();
    endtask

    // Monitor: a response must match the queue head every cycle it is shown.
    always @(negedge CLK) begin
        if (!RST && bus.resp_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp: got rdata %0h, required no response", bus.resp_rdata);
            end else begin
                chk("resp_rdata", 32'(bus.resp_rdata), 32'(sb[0].d));
`ifdef DMEM_RANGE_CHECK_EN
                chk("resp_err", 32'(bus.resp_err), 32'(sb[0].e));
`endif
                if (bus.resp_ready) begin
                    void'(sb.pop_front());
                    resp_cnt++;
                end
            end
        end
    end

    initial begin
        int base;
        logic [15:0] pre5;

        RST            = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_rd     = 1'b0;
        bus.req_wr     = 1'b0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.resp_ready = 1'b0;

        // Reset and idle
        repeat (2) begin
            tick();
            chk("ready_in_reset", 32'(bus.req_ready), 32'd0);
        end
        RST = 1'b0;
        #1;
        chk("ready_after_reset", 32'(bus.req_ready), 32'd1);
        chk("valid_after_reset", 32'(bus.resp_valid), 32'd0);
        chk("pending_after_reset", 32'(bus.pending), 32'd0);
        chk("rdata_after_reset", 32'(bus.resp_rdata), 32'd0);

        // Store then load, with latency probe
        bus.resp_ready = 1'b1;
        send(1'b0, 1'b1, 16'h0005, 16'h1234);
        chk("pending_one", 32'(bus.pending), 32'd1);
        expect_load(16'h0005, 16'h1234, 1'b0);
        tick();
        tick();
        chk("lat_not_yet", 32'(bus.resp_valid), 32'd0);
        tick();
        chk("lat_valid", 32'(bus.resp_valid), 32'd1);
        wait_idle();

        // Full queue under backpressure
        for (int i = 0; i < 6; i++) send(1'b0, 1'b1, 16'(16'h0010 + i), 16'(16'hA000 + i));
        wait_idle();
        bus.resp_ready = 1'b0;
        base = resp_cnt;
        fork
            begin
                for (int i = 0; i < 6; i++) expect_load(16'(16'h0010 + i), 16'(16'hA000 + i), 1'b0);
            end
            begin
                int n = 0;
                while (bus.pending != 4 && n < 200) begin
                    tick();
                    n++;
                end
                chk("pending_full", 32'(bus.pending), 32'd4);
                chk("ready_full", 32'(bus.req_ready), 32'd0);
                repeat (5) tick();
                chk("ready_still_full", 32'(bus.req_ready), 32'd0);
                bus.resp_ready = 1'b1;
            end
        join
        wait_idle();
        chk("full_resp_count", 32'(resp_cnt - base), 32'd6);

        // Address wrap / out-of-range
        send(1'b0, 1'b1, 16'h0105, 16'hBEEF);
`ifdef DMEM_RANGE_CHECK_EN
        expect_load(16'h0105, 16'h0000, 1'b1);
        expect_load(16'h0005, 16'h1234, 1'b0);
        send(1'b0, 1'b1, 16'h0105, 16'hAAAA);
        expect_load(16'h0105, 16'h0000, 1'b1);
        expect_load(16'h0005, 16'h1234, 1'b0);
        pre5 = 16'h1234;
`else
        expect_load(16'h0005, 16'hBEEF, 1'b0);
        pre5 = 16'hBEEF;
`endif
        wait_idle();

        // rd=wr=1 is a store with no response
        base = resp_cnt;
        send(1'b1, 1'b1, 16'h0020, 16'h0077);
        wait_idle();
        chk("rdwr_no_resp", 32'(resp_cnt - base), 32'd0);
        expect_load(16'h0020, 16'h0077, 1'b0);
        wait_idle();

        // Bubble occupies nothing
        base = resp_cnt;
        send(1'b0, 1'b0, 16'h0020, 16'h0000);
        chk("bubble_pending", 32'(bus.pending), 32'd0);
        repeat (4) tick();
        chk("bubble_no_resp", 32'(resp_cnt - base), 32'd0);

        // Reset while a load waits; the queued store must be dropped
        base = resp_cnt;
        send(1'b1, 1'b0, 16'h0005, 16'h0000);
        send(1'b0, 1'b1, 16'h0005, 16'hDEAD);
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
        #1;
        chk("pending_after_midreset", 32'(bus.pending), 32'd0);
        chk("valid_after_midreset", 32'(bus.resp_valid), 32'd0);
        repeat (6) tick();
        chk("midreset_no_resp", 32'(resp_cnt - base), 32'd0);
        expect_load(16'h0005, pre5, 1'b0);
        wait_idle();
        chk("midreset_load_resp", 32'(resp_cnt - base), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder serving the datapath's memory-stage requests (address, store data, MemRd, MemWr) over a valid/ready request channel.
- Returns load data over a valid/ready response channel; sits between the processor's MEM stage and the data storage array.
- Buffers requests in a small in-order queue and services them one at a time with a fixed, parameterised read latency, so the pipeline can later stall on memory instead of assuming single-cycle access.

Parameters:
- DATA_W, 16: data word width (bits).
- ADDR_W, 8: word-address width; the array holds 2^ADDR_W words.
- RD_LATENCY, 2: cycles from the engine popping a load to resp_valid rising; legal range is 1 or more.
- Q_DEPTH, 4: request queue entries; power of 2, at least 2.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  synchronous active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  queue can accept a request.
- req_rd  in  1  load request (MemRd).
- req_wr  in  1  store request (MemWr).
- req_addr  in  16  word address (ALU output).
- req_wdata  in  DATA_W  store data (BusB).
- resp_valid  out  1  load data available.
- resp_ready  in  1  consumer accepts the response.
- resp_rdata  out  DATA_W  load data.
- pending  out  $clog2(Q_DEPTH)+1  queue occupancy.

Behaviour:
- Reset (RST=1 at an edge):
  - queue is emptied, FSM goes to IDLE, latency counter is set to 0.
  - resp_valid=0, resp_rdata=0, pending=0.
  - req_ready=0 while RST is high and 1 after RST falls.
  - Array contents are not reset.
- Reset mid-operation: any queued or in-flight operation is discarded; no response is produced. A store that has not yet been popped is not written.
- Accept: a request is accepted when req_valid && req_ready at an edge.
  - req_ready = !full; there is no same-cycle pass-through, so a full queue stays not-ready even if a pop happens in that cycle.
- Request decode:
  - req_wr=1 is a store, regardless of req_rd. Asserting both is illegal and is treated as a store with no response.
  - req_rd=1, req_wr=0 is a load.
  - Neither set is a bubble: it is accepted and discarded at enqueue and never occupies the queue.
- Address: only req_addr[ADDR_W-1:0] is used; upper bits are ignored, so addresses wrap modulo 2^ADDR_W.
- FSM states are IDLE, WAIT and RESP.
  - IDLE with queue non-empty: pop the head.
    - Store: the array is written at that edge and the FSM stays in IDLE, giving 1 store per cycle throughput.
    - Load: the array word is captured and the FSM goes to WAIT with cnt=RD_LATENCY-1.
  - WAIT: if cnt==0, go to RESP and assert resp_valid, with resp_rdata = captured word. Otherwise decrement cnt.
  - RESP: resp_valid and resp_rdata are held stable until resp_ready=1 at an edge, then the FSM returns to IDLE. The next pop happens no earlier than the following edge.
- Latency: for a load accepted at edge t into an empty queue with the FSM in IDLE, resp_valid is first high in the cycle after edge t+1+RD_LATENCY.
- Ordering:
  - Strictly in order.
  - A load queued after a store to the same address returns the new data.
  - A store queued behind a load waits until that load's response is consumed.
- pending: updated at each edge as +1 on push, -1 on pop, unchanged on simultaneous push and pop. Range is 0..Q_DEPTH.
- resp_valid never asserts for stores or bubbles.

Optional Feature:
- DMEM_RANGE_CHECK_EN, defined:
  - Adds output port resp_err (1 bit, reset 0).
  - A request with req_addr[15:ADDR_W] != 0 is out of range.
  - Out-of-range store: suppressed, no array write.
  - Out-of-range load: responds with resp_rdata=0 and resp_err=1. resp_err is valid only while resp_valid=1 and is 0 for in-range loads.
- DMEM_RANGE_CHECK_EN, undefined: no resp_err port; addresses wrap as above.

Decomposition:
- Package dmem_pkg:
  - FSM state enum (IDLE, WAIT, RESP).
  - Request-kind encoding (LOAD, STORE).
  - Queue entry struct {kind, addr, wdata}.
  - Default width constants.
- Sub-module dmem_req_fifo: synchronous FIFO of queue entries with full, empty and count outputs and synchronous active-high reset.
- The FSM and array stay in dmem_responder.

Test Plan:
- Reset/idle: hold RST=1 for 2 cycles, then release -> req_ready=0 during reset; after release req_ready=1, resp_valid=0, pending=0.
- Store then load: store 0x1234 to addr 0x05, then load addr 0x05 (RD_LATENCY=2, resp_ready=1) -> one response, resp_rdata=0x1234, resp_valid high 3 cycles after the load-accept edge.
- Full queue with backpressure: hold resp_ready=0 and issue 6 loads back to back -> req_ready falls once pending reaches 4; exactly 6 responses are eventually produced, in order; resp_rdata stays stable while resp_ready=0.
- Wrap and illegal requests:
  - Store 0xBEEF to 0x0105, then load 0x0005 -> 0xBEEF (macro off).
  - req_rd=req_wr=1 -> stored, no response.
  - rd=wr=0 -> no response and pending unchanged.
- Reset mid-load: reset while in WAIT -> resp_valid never rises for that load; a following load to addr 0x05 returns the pre-reset array value.
- DMEM_RANGE_CHECK_EN defined: store 0xAAAA to 0x0105, then load 0x0105 and load 0x0005 -> first load gives resp_err=1 with rdata=0; second gives resp_err=0 with the previous contents (unchanged).
